// File: rtl/mini_core_pkg.sv
// Shared core/memory types: the core-to-memory request bundle and the
// data-memory responder state encoding.
package mini_core_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef struct packed {
    logic        RdEn;
    logic        WrEn;
    logic [3:0]  ByteEn;
    logic [31:0] Address;
    logic [31:0] WrData;
  } t_core2mem_req;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } t_dmem_rsp_state;

  // Stall counter width: enough to hold waitCycles-1, never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned waitCycles);
    return (waitCycles > 0) ? (($clog2(waitCycles + 1) > 0) ? $clog2(waitCycles + 1) : 1) : 1;
  endfunction

endpackage

// File: rtl/mini_mem_dmem_array.sv
// Word-organised data RAM with per-byte write enables and a registered,
// read-first read port, shaped so FPGA tools map it onto block RAM.
module mini_mem_dmem_array
  import mini_core_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic          Clock,
  input  logic [3:0]    WrByteEn,
  input  logic          RdEn,
  input  logic [AW-1:0] Idx,
  input  logic [31:0]   WrData,
  output logic [31:0]   RdData
);

  logic [31:0] mem [2**AW];

  // Synchronous read of the old word and byte-lane writes in the same edge.
  always_ff @(posedge Clock) begin
    if (RdEn) begin
      RdData <= mem[Idx];
    end
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (WrByteEn[b]) begin
        mem[Idx][8*b +: 8] <= WrData[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mini_mem_dmem_rsp.sv
// Data-memory responder: stalls each request a fixed number of cycles,
// decodes the address window, returns read data one cycle after acceptance
// and latches the first out-of-window address.
//
//  state | meaning
//  IDLE  | no request in flight; zero-wait requests are accepted here
//  WAIT  | request being stalled; accepted when cnt reaches 0
module mini_mem_dmem_rsp
  import mini_core_pkg::*;
#(
  parameter int unsigned MEM_AW      = 10,
  parameter logic [31:0] MEM_BASE    = 32'h0000_1000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          Clock,
  input  logic          Rst,
  input  t_core2mem_req Core2DmemReqQ103H,
  output logic          DMemReady,
  output logic [31:0]   DMemRdRspQ104H,
  output logic          AccessErr,
  output logic [31:0]   ErrAddr
);

  localparam int unsigned     CNT_W    = cntWidth(WAIT_CYCLES);
  localparam bit              HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  t_dmem_rsp_state state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt;

  logic              req;
  logic              accept;
  logic              inWin;
  logic [MEM_AW-1:0] idx;
  logic              rdAccept;
  logic [3:0]        wrByteEn;
  logic [31:0]       arrRdData;
  logic              rdPending;
  logic              rdInWin;
  logic [31:0]       rspHold;
  logic              unusedAddrLsb;

  assign req   = Core2DmemReqQ103H.RdEn | Core2DmemReqQ103H.WrEn;
  assign inWin = (Core2DmemReqQ103H.Address[31:MEM_AW+2] == MEM_BASE[31:MEM_AW+2]);
  assign idx   = Core2DmemReqQ103H.Address[MEM_AW+1:2];
  // Lane selection is by ByteEn alone; the byte offset is not needed.
  assign unusedAddrLsb = ^Core2DmemReqQ103H.Address[1:0];

  // Reset gates acceptance so a pending access is discarded, not committed.
  assign accept   = req & DMemReady & ~Rst;
  assign rdAccept = accept & Core2DmemReqQ103H.RdEn;
  assign wrByteEn = (accept & Core2DmemReqQ103H.WrEn & inWin) ? Core2DmemReqQ103H.ByteEn : 4'b0000;

  // State register and stall down-counter.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Next state: load the stall count on a new request, count down to terminal 0.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      IDLE: begin
        if (req && HAS_WAIT) begin
          nextState = WAIT;
          nextCnt   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          nextCnt = cnt - CNT_W'(1);
        end else begin
          nextState = IDLE;
        end
      end
    endcase
  end

  // Ready: high when idle with nothing to stall, or at the terminal count.
  always_comb begin
    DMemReady = 1'b1;
    case (state)
      IDLE: DMemReady = !(req && HAS_WAIT);
      WAIT: DMemReady = (cnt == '0);
    endcase
  end

  mini_mem_dmem_array #(
    .AW(MEM_AW)
  ) uArray (
    .Clock    (Clock),
    .WrByteEn (wrByteEn),
    .RdEn     (rdAccept & inWin),
    .Idx      (idx),
    .WrData   (Core2DmemReqQ103H.WrData),
    .RdData   (arrRdData)
  );

  // Track the read in flight so the response shows RAM data (or 0) for one
  // cycle and otherwise holds the last response; the RAM itself is not reset.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      rdPending <= 1'b0;
      rdInWin   <= 1'b0;
      rspHold   <= '0;
    end else begin
      rdPending <= rdAccept;
      rdInWin   <= inWin;
      rspHold   <= DMemRdRspQ104H;
    end
  end

  assign DMemRdRspQ104H = rdPending ? (rdInWin ? arrRdData : 32'h0) : rspHold;

  // Sticky error flag; address captured only for the first offending access.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      AccessErr <= 1'b0;
      ErrAddr   <= '0;
    end else if (accept && !inWin) begin
      AccessErr <= 1'b1;
      if (!AccessErr) begin
        ErrAddr <= Core2DmemReqQ103H.Address;
      end
    end
  end

endmodule

// File: tb/tb_mini_mem_dmem_rsp.sv
// Bench for mini_mem_dmem_rsp: a zero-wait instance and a 3-wait instance
// run side by side against a transaction-level model.
module tb_mini_mem_dmem_rsp;
  import mini_core_pkg::*;

  localparam int unsigned AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic                   clk = 1'b0;
  logic [1:0]             rst;
  t_core2mem_req [1:0]    req;
  logic [1:0]             rdy;
  logic [1:0][31:0]       rsp;
  logic [1:0]             err;
  logic [1:0][31:0]       ea;

  int checks   = 0;
  int failures = 0;
  bit chkEn    = 1'b0;

  // model state
  int        age [2];
  bit [31:0] mMem [2][1024];
  bit [31:0] mRsp [2];
  bit        mErr [2];
  bit [31:0] mEa  [2];

  always #5 clk = ~clk;

  mini_mem_dmem_rsp #(.MEM_AW(AW), .MEM_BASE(BASE), .WAIT_CYCLES(0)) dut0 (
    .Clock(clk), .Rst(rst[0]), .Core2DmemReqQ103H(req[0]),
    .DMemReady(rdy[0]), .DMemRdRspQ104H(rsp[0]), .AccessErr(err[0]), .ErrAddr(ea[0])
  );

  mini_mem_dmem_rsp #(.MEM_AW(AW), .MEM_BASE(BASE), .WAIT_CYCLES(3)) dut3 (
    .Clock(clk), .Rst(rst[1]), .Core2DmemReqQ103H(req[1]),
    .DMemReady(rdy[1]), .DMemRdRspQ104H(rsp[1]), .AccessErr(err[1]), .ErrAddr(ea[1])
  );

  function automatic int waitOf(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One accepted access as the spec describes it: window test by address
  // range, old word returned, enabled bytes overwritten.
  task automatic modelAccess(input int d);
    logic [31:0] a, off, old, nw;
    bit          win;
    a   = req[d].Address;
    off = a - BASE;
    win = (a >= BASE) && (off < (32'd4 << AW));
    if (!win) begin
      if (!mErr[d]) mEa[d] = a;
      mErr[d] = 1'b1;
      if (req[d].RdEn) mRsp[d] = 32'h0;
    end else begin
      old = mMem[d][off / 4];
      if (req[d].RdEn) mRsp[d] = old;
      if (req[d].WrEn) begin
        nw = old;
        for (int b = 0; b < 4; b++)
          if (req[d].ByteEn[b]) nw[8*b +: 8] = req[d].WrData[8*b +: 8];
        mMem[d][off / 4] = nw;
      end
    end
  endtask

  // Model: a held request is accepted after exactly waitOf(d) stalled cycles.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        age[d]  = 0;
        mRsp[d] = 32'h0;
        mErr[d] = 1'b0;
        mEa[d]  = 32'h0;
      end else if (req[d].RdEn || req[d].WrEn) begin
        if (age[d] == waitOf(d)) begin
          modelAccess(d);
          age[d] = 0;
        end else begin
          age[d]++;
        end
      end else begin
        age[d] = 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  logic expRdy;
  always @(negedge clk) begin
    if (chkEn) begin
      for (int d = 0; d < 2; d++) begin
        expRdy = !(req[d].RdEn || req[d].WrEn) || (age[d] == waitOf(d));
        chk($sformatf("ready[%0d]", d), {31'b0, rdy[d]}, {31'b0, expRdy});
        chk($sformatf("rsp[%0d]", d), rsp[d], mRsp[d]);
        chk($sformatf("accessErr[%0d]", d), {31'b0, err[d]}, {31'b0, mErr[d]});
        chk($sformatf("errAddr[%0d]", d), ea[d], mEa[d]);
      end
    end
  end

  // Present a request, hold it until accepted, return the stall count.
  task automatic acc(input int d, input logic rd, input logic wr, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] wd, output int stalls);
    req[d].RdEn    = rd;
    req[d].WrEn    = wr;
    req[d].ByteEn  = be;
    req[d].Address = a;
    req[d].WrData  = wd;
    stalls = 0;
    #1;
    while (!rdy[d] && stalls < 20) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (stalls >= 20) begin
      failures++;
      $display("FAIL acceptTimeout[%0d] actual=never required=ready", d);
    end
    @(posedge clk); #1;
    req[d] = '0;
  endtask

  int n;

  initial begin
    req = '0;
    rst = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b00;
    chkEn = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("resetReady", {31'b0, rdy[d]}, 32'd1);
      chk("resetRsp", rsp[d], 32'h0);
      chk("resetErr", {31'b0, err[d]}, 32'd0);
      chk("resetErrAddr", ea[d], 32'h0);
    end

    // zero-wait write then read
    acc(0, 1'b0, 1'b1, 4'hF, 32'h1004, 32'hDEADBEEF, n);
    chk("t1WrStalls", n, 0);
    acc(0, 1'b1, 1'b0, 4'hF, 32'h1004, 32'h0, n);
    chk("t1RdStalls", n, 0);
    #1;
    chk("t1Rsp", rsp[0], 32'hDEADBEEF);
    chk("t1Model", mRsp[0], 32'hDEADBEEF);

    // byte enables
    acc(0, 1'b0, 1'b1, 4'hF, 32'h1008, 32'h11223344, n);
    acc(0, 1'b0, 1'b1, 4'b0101, 32'h1008, 32'hAABBCCDD, n);
    acc(0, 1'b0, 1'b1, 4'b0000, 32'h1008, 32'hFFFFFFFF, n);
    acc(0, 1'b1, 1'b0, 4'hF, 32'h1008, 32'h0, n);
    #1;
    chk("t2Rsp", rsp[0], 32'h11BB33DD);
    chk("t2Model", mRsp[0], 32'h11BB33DD);

    // three-cycle stall, back-to-back requests each stall again
    acc(1, 1'b0, 1'b1, 4'hF, 32'h1004, 32'h13579BDF, n);
    chk("t3WrStalls", n, 3);
    acc(1, 1'b1, 1'b0, 4'hF, 32'h1004, 32'h0, n);
    chk("t3RdStalls", n, 3);
    #1;
    chk("t3Rsp", rsp[1], 32'h13579BDF);
    acc(1, 1'b1, 1'b0, 4'hF, 32'h1004, 32'h0, n);
    chk("t3BackToBack", n, 3);

    // read-first on simultaneous read/write
    acc(0, 1'b0, 1'b1, 4'hF, 32'h100C, 32'h0, n);
    acc(0, 1'b1, 1'b1, 4'hF, 32'h100C, 32'h5, n);
    #1;
    chk("t4OldWord", rsp[0], 32'h0);
    acc(0, 1'b1, 1'b0, 4'hF, 32'h100C, 32'h0, n);
    #1;
    chk("t4NewWord", rsp[0], 32'h5);

    // out of window: write dropped, read returns 0, first address kept
    acc(0, 1'b0, 1'b1, 4'hF, 32'h1000, 32'hCAFE0000, n);
    acc(0, 1'b0, 1'b1, 4'hF, 32'h2000, 32'h12345678, n);
    acc(0, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0, n);
    #1;
    chk("t5Rsp", rsp[0], 32'h0);
    chk("t5Err", {31'b0, err[0]}, 32'd1);
    chk("t5ErrAddr", ea[0], 32'h2000);
    acc(0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, n);
    #1;
    chk("t5RamUnchanged", rsp[0], 32'hCAFE0000);

    // reset during a stalled write discards it and clears the error
    acc(1, 1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0, n);
    #1;
    chk("t6ErrSet", {31'b0, err[1]}, 32'd1);
    acc(1, 1'b0, 1'b1, 4'hF, 32'h1010, 32'h600DCAFE, n);
    req[1].RdEn    = 1'b0;
    req[1].WrEn    = 1'b1;
    req[1].ByteEn  = 4'hF;
    req[1].Address = 32'h1010;
    req[1].WrData  = 32'hBAD0BAD0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    req[1] = '0;
    #1;
    chk("t6Ready", {31'b0, rdy[1]}, 32'd1);
    chk("t6ErrCleared", {31'b0, err[1]}, 32'd0);
    chk("t6RspCleared", rsp[1], 32'h0);
    acc(1, 1'b1, 1'b0, 4'hF, 32'h1010, 32'h0, n);
    #1;
    chk("t6PriorWord", rsp[1], 32'h600DCAFE);
    chk("t6Model", mRsp[1], 32'h600DCAFE);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
